sr_piso_tx: RTL and testbench

- Parallel-in, serial-out shift-register transmitter: the serializing partner of the team's 4-bit parallel register.
- Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per clock.
- Marks each valid bit and the final bit of every frame.
- Supports gapless back-to-back frames, so a downstream serial-in receiver sees a continuous stream.

---
 rtl/sr_piso_tx.sv | 138 +++++++++++++
 tb/tb_sr_piso_tx.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sr_piso_tx.sv
// -----------------------------------------------------------------------------
// sr_piso_tx -- parallel-in, serial-out shift-register transmitter.
//
// A WIDTH-bit word is accepted through a valid/ready handshake and sent out
// one bit per clock, starting in the cycle after the accepting edge. A word
// offered during the last bit of a frame is accepted on that edge, so
// consecutive frames follow each other with no idle cycle.
//
// Optional feature (compile-time macro SR_PISO_PARITY_EN):
//   appends an even-parity bit (XOR of the captured word) after the data bits.
//   With the macro undefined, no parity logic or register exists.
//
// Parameters:
//   WIDTH      data word width, 2..32
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   pi          parallel word, sampled only on the accepting edge
//   load_valid  upstream has a word on pi
//   load_ready  a word can be accepted this cycle (0 while in reset)
//   so          serial data bit (0 when idle)
//   so_valid    so carries a frame bit this cycle
//   so_last     so carries the final bit of the frame
//   busy        a frame is in progress (same as so_valid)
// -----------------------------------------------------------------------------
module sr_piso_tx #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pi,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             so,
  output logic             so_valid,
  output logic             so_last,
  output logic             busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

`ifdef SR_PISO_PARITY_EN
  localparam int unsigned FRAME_LEN = WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN = WIDTH;
`endif
  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SR_PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic in_shift;
  logic last_bit;
  logic load;
  logic data_bit;

  assign in_shift = (state_q == SHIFT);
  assign last_bit = in_shift && (cnt_q == LAST_CNT);

  // reset is folded in so nothing upstream sees a ready while we are held.
  assign load_ready = reset && (!in_shift || last_bit);
  assign load       = load_valid && load_ready;

  // NOTE: every always_comb output gets a default first so no path can leave
  // a variable unassigned, which would infer a latch.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
`ifdef SR_PISO_PARITY_EN
    parity_d = parity_q;
`endif
    if (load) begin
      // Also covers the end-of-frame reload that makes frames gapless.
      state_d  = SHIFT;
      sh_d     = pi;
      cnt_d    = '0;
`ifdef SR_PISO_PARITY_EN
      parity_d = ^pi;
`endif
    end else if (in_shift) begin
      if (last_bit) begin
        state_d = IDLE;
        sh_d    = '0;
        cnt_d   = '0;
      end else begin
        sh_d  = MSB_FIRST ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, and every flop
  // is cleared by the asynchronous reset so outputs drop without a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
`ifdef SR_PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
`ifdef SR_PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // The outgoing bit is always the register end that shifts out next; the
  // parity register takes over for the extra final bit.
  always_comb begin
    data_bit = MSB_FIRST ? sh_q[WIDTH-1] : sh_q[0];
`ifdef SR_PISO_PARITY_EN
    if (cnt_q == LAST_CNT) data_bit = parity_q;
`endif
  end

  assign so       = in_shift && data_bit;
  assign so_valid = in_shift;
  assign so_last  = last_bit;
  assign busy     = in_shift;

endmodule

// File: tb/tb_sr_piso_tx.sv
// -----------------------------------------------------------------------------
// tb_sr_piso_tx -- directed bench for sr_piso_tx (WIDTH=4).
// An MSB-first and an LSB-first instance share the same stimulus; each check
// compares both instances at once. Expected streams are hand-written
// constants, with the parity variants selected by SR_PISO_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_sr_piso_tx;

  localparam int W = 4;
`ifdef SR_PISO_PARITY_EN
  localparam int FL = W + 1;
  // first bit of the frame is the leftmost of the FL used bits
  localparam logic [4:0] M_1011 = 5'b10111;
  localparam logic [4:0] L_1011 = 5'b11011;
  localparam logic [4:0] M_0110 = 5'b01100;
  localparam logic [4:0] L_0110 = 5'b01100;
`else
  localparam int FL = W;
  localparam logic [4:0] M_1011 = 5'b01011;
  localparam logic [4:0] L_1011 = 5'b01101;
  localparam logic [4:0] M_0110 = 5'b00110;
  localparam logic [4:0] L_0110 = 5'b00110;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] pi = '0;
  logic         load_valid = 1'b0;

  logic rdy_m, so_m, sov_m, sol_m, busy_m;
  logic rdy_l, so_l, sov_l, sol_l, busy_l;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  sr_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .pi(pi), .load_valid(load_valid),
    .load_ready(rdy_m), .so(so_m), .so_valid(sov_m), .so_last(sol_m),
    .busy(busy_m)
  );

  sr_piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .pi(pi), .load_valid(load_valid),
    .load_ready(rdy_l), .so(so_l), .so_valid(sov_l), .so_last(sol_l),
    .busy(busy_l)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Both instances idle: every output 0, load_ready as given.
  task automatic check_idle(input string tag, input logic rdy);
    check({tag, " so"},    {so_m, so_l},     2'b00);
    check({tag, " valid"}, {sov_m, sov_l},   2'b00);
    check({tag, " last"},  {sol_m, sol_l},   2'b00);
    check({tag, " busy"},  {busy_m, busy_l}, 2'b00);
    check({tag, " ready"}, {rdy_m, rdy_l},   {rdy, rdy});
  endtask

  // Offer a word; hold keeps load_valid high after the accepting edge.
  task automatic load_word(input logic [W-1:0] w, input bit hold);
    pi         = w;
    load_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) load_valid = 1'b0;
  endtask

  // Called just after the accepting edge. Checks FL bits at negedges; if
  // pulse_at >= 0 a 4'b1111 load is offered while that bit is on the line.
  // Returns just after the edge that ends the frame, with load_valid low.
  task automatic check_frame(input string tag, input logic [4:0] m_exp,
                             input logic [4:0] l_exp, input int pulse_at);
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      if (i == pulse_at + 1 && pulse_at >= 0) load_valid = 1'b0;
      check($sformatf("%s bit%0d so", tag, i), {so_m, so_l},
            {m_exp[FL-1-i], l_exp[FL-1-i]});
      check($sformatf("%s bit%0d valid", tag, i), {sov_m, sov_l, busy_m, busy_l},
            4'b1111);
      check($sformatf("%s bit%0d last", tag, i), {sol_m, sol_l},
            (i == FL - 1) ? 2'b11 : 2'b00);
      check($sformatf("%s bit%0d ready", tag, i), {rdy_m, rdy_l},
            (i == FL - 1) ? 2'b11 : 2'b00);
      if (i == pulse_at) begin
        pi         = 4'b1111;
        load_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  initial begin
    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("in_reset", 1'b0);
    reset = 1'b1;
    #1;
    check_idle("idle_after_reset", 1'b1);

    // Single frame, both shift orders.
    load_word(4'b1011, 1'b0);
    check_frame("single", M_1011, L_1011, -1);
    @(negedge clk);
    check_idle("after_single", 1'b1);

    // Back-to-back: 0110 is held and taken on the last-bit edge.
    load_word(4'b1011, 1'b1);
    pi = 4'b0110;
    check_frame("b2b_a", M_1011, L_1011, -1);
    check_frame("b2b_b", M_0110, L_0110, -1);
    @(negedge clk);
    check_idle("after_b2b", 1'b1);

    // Load offered during bit 2 must be ignored.
    load_word(4'b1011, 1'b0);
    check_frame("busy_load", M_1011, L_1011, 1);
    @(negedge clk);
    check_idle("after_busy_load", 1'b1);

    // Asynchronous reset in the middle of bit 2.
    load_word(4'b1011, 1'b0);
    @(posedge clk);
    #2;
    check("pre_reset lsb bit2", {sov_l, so_l}, 2'b11);
    reset = 1'b0;
    #1;
    check_idle("mid_reset", 1'b0);
    @(negedge clk);
    check_idle("mid_reset_held", 1'b0);
    reset = 1'b1;
    #1;
    check_idle("mid_reset_release", 1'b1);
    load_word(4'b0110, 1'b0);
    check_frame("after_reset", M_0110, L_0110, -1);
    @(negedge clk);
    check_idle("final_idle", 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #20000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
